// File: rtl/uart_rx_fifo_if.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_if
// Description : Receive byte stream (valid/ready) plus error pulses.
// Revision    : 1.0 - initial release
// ============================================================================
interface uart_rx_fifo_if;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic       frame_err;
  logic       overrun;

  modport master (
    output rx_data,
    output rx_valid,
    input  rx_ready,
    output frame_err,
    output overrun
  );

  modport slave (
    input  rx_data,
    input  rx_valid,
    output rx_ready,
    input  frame_err,
    input  overrun
  );
endinterface
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver with first-word-fall-through byte FIFO.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo #(
  parameter int CLK_DIV    = 434,
  parameter int FIFO_DEPTH = 4
) (
  input  logic            clk,
  input  logic            resetn,
  input  logic            ser_rx,
  uart_rx_fifo_if.master  rx
);

  localparam int c_cnt_w = $clog2(CLK_DIV);
  localparam int c_ptr_w = $clog2(FIFO_DEPTH);

  localparam logic [c_cnt_w-1:0] c_half  = c_cnt_w'(CLK_DIV / 2 - 1);
  localparam logic [c_cnt_w-1:0] c_last  = c_cnt_w'(CLK_DIV - 1);
  localparam logic [c_ptr_w:0]   c_depth = (c_ptr_w + 1)'(FIFO_DEPTH);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_BREAK = 3'd4
  } state_t;

  // --------------------------------------------------------------------------
  // Input synchroniser (idle-high reset value so reset looks like an idle line)
  // --------------------------------------------------------------------------
  logic r_sync1;
  logic r_sync2;
  logic w_rxs;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_sync1 <= 1'b1;
      r_sync2 <= 1'b1;
    end else begin
      r_sync1 <= ser_rx;
      r_sync2 <= r_sync1;
    end
  end

  assign w_rxs = r_sync2;

  // --------------------------------------------------------------------------
  // Frame decoder
  // --------------------------------------------------------------------------
  state_t             r_state;
  state_t             w_state_nx;
  logic [c_cnt_w-1:0] r_cnt;
  logic [c_cnt_w-1:0] w_cnt_nx;
  logic [2:0]         r_idx;
  logic [2:0]         w_idx_nx;
  logic [7:0]         r_shift;
  logic [7:0]         w_shift_nx;
  logic               w_push_req;
  logic               w_stop_low;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state <= S_IDLE;
      r_cnt   <= '0;
      r_idx   <= '0;
      r_shift <= '0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_idx   <= w_idx_nx;
      r_shift <= w_shift_nx;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_idx_nx   = r_idx;
    w_shift_nx = r_shift;
    w_push_req = 1'b0;
    w_stop_low = 1'b0;

    case (r_state)
      S_IDLE: begin
        w_cnt_nx = '0;
        if (!w_rxs) begin
          w_state_nx = S_START;
        end
      end

      S_START: begin
        if (r_cnt == c_half) begin
          w_cnt_nx = '0;
          if (w_rxs) begin
            w_state_nx = S_IDLE;
          end else begin
            w_state_nx = S_DATA;
            w_idx_nx   = 3'd0;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end

      // Start sample was mid-bit, so every full bit period later is mid-bit too
      S_DATA: begin
        if (r_cnt == c_last) begin
          w_cnt_nx   = '0;
          w_shift_nx = {w_rxs, r_shift[7:1]};
          if (r_idx == 3'd7) begin
            w_state_nx = S_STOP;
          end else begin
            w_idx_nx = r_idx + 3'd1;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end

      S_STOP: begin
        if (r_cnt == c_last) begin
          w_cnt_nx = '0;
          if (w_rxs) begin
            w_push_req = 1'b1;
            w_state_nx = S_IDLE;
          end else begin
            w_stop_low = 1'b1;
            w_state_nx = S_BREAK;
          end
        end else begin
          w_cnt_nx = r_cnt + 1'b1;
        end
      end

      S_BREAK: begin
        w_cnt_nx = '0;
        if (w_rxs) begin
          w_state_nx = S_IDLE;
        end
      end

      default: begin
        w_state_nx = S_IDLE;
        w_cnt_nx   = '0;
      end
    endcase
  end

  // --------------------------------------------------------------------------
  // Receive FIFO
  // --------------------------------------------------------------------------
  logic [7:0]         r_mem [FIFO_DEPTH];
  logic [c_ptr_w-1:0] r_wr_ptr;
  logic [c_ptr_w-1:0] r_rd_ptr;
  logic [c_ptr_w:0]   r_count;
  logic               w_rx_valid;
  logic               w_pop;
  logic               w_push;
  logic               w_drop;
  logic               r_frame_err;
  logic               r_overrun;

  assign w_rx_valid = (r_count != '0);
  assign w_pop      = w_rx_valid & rx.rx_ready;
  // A full FIFO still takes the byte when the head leaves on the same edge
  assign w_push     = w_push_req & ((r_count != c_depth) | w_pop);
  assign w_drop     = w_push_req & ~w_push;

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        r_mem[i] <= '0;
      end
    end else if (w_push) begin
      r_mem[r_wr_ptr] <= r_shift;
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_frame_err <= 1'b0;
      r_overrun   <= 1'b0;
    end else begin
      r_frame_err <= w_stop_low;
      r_overrun   <= w_drop;
    end
  end

  assign rx.rx_data   = r_mem[r_rd_ptr];
  assign rx.rx_valid  = w_rx_valid;
  assign rx.frame_err = r_frame_err;
  assign rx.overrun   = r_overrun;

endmodule
`default_nettype wire

// File: tb/tb_uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_rx_fifo
// Description : Directed bench for uart_rx_fifo (CLK_DIV=8, FIFO_DEPTH=4).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_rx_fifo;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic ser_rx = 1'b1;

  uart_rx_fifo_if rx_if ();

  uart_rx_fifo #(
    .CLK_DIV    (8),
    .FIFO_DEPTH (4)
  ) dut (
    .clk    (clk),
    .resetn (resetn),
    .ser_rx (ser_rx),
    .rx     (rx_if)
  );

  always #5 clk = ~clk;

  int n_pass  = 0;
  int n_total = 0;

  // Event monitor: cycle count, rx_valid rising edges, pulse counters
  int   cyc = 0;
  int   last_rise = 0;
  int   fe_cnt = 0;
  int   ov_cnt = 0;
  int   both_cnt = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (rx_if.rx_valid && !prev_valid) last_rise = cyc;
    prev_valid = rx_if.rx_valid;
    if (rx_if.frame_err) fe_cnt++;
    if (rx_if.overrun) ov_cnt++;
    if (rx_if.frame_err && rx_if.overrun) both_cnt++;
  end

  task automatic send_frame(input logic [7:0] d, input logic stop, input int extra_low,
                            output int t0);
    @(negedge clk);
    ser_rx = 1'b0;
    t0 = cyc;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 8; i++) begin
      ser_rx = d[i];
      repeat (8) @(negedge clk);
    end
    ser_rx = stop;
    repeat (8 + extra_low) @(negedge clk);
    ser_rx = 1'b1;
  endtask

  task automatic pop_byte(output logic [7:0] d);
    @(negedge clk);
    d = rx_if.rx_data;
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
  endtask

  task automatic test_reset();
    rx_if.rx_ready = 1'b0;
    resetn = 1'b0;
    repeat (3) @(negedge clk);
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL reset_valid got %b exp 0", rx_if.rx_valid); else n_pass++;
    n_total++; if (rx_if.rx_data !== 8'h00) $display("FAIL reset_data got %h exp 00", rx_if.rx_data); else n_pass++;
    n_total++; if ({rx_if.frame_err, rx_if.overrun} !== 2'b00) $display("FAIL reset_pulses got %b exp 00", {rx_if.frame_err, rx_if.overrun}); else n_pass++;
    resetn = 1'b1;
    repeat (10) @(negedge clk);
  endtask

  task automatic test_single();
    int t0, fe0, ov0, lat;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'hA5, 1'b1, 0, t0);
    lat = last_rise - t0;
    n_total++; if (lat < 76 || lat > 80) $display("FAIL single_latency got %0d exp 76..80", lat); else n_pass++;
    n_total++; if (rx_if.rx_data !== 8'hA5) $display("FAIL single_data got %h exp a5", rx_if.rx_data); else n_pass++;
    repeat (20) @(negedge clk);
    n_total++; if ({rx_if.rx_valid, rx_if.rx_data} !== {1'b1, 8'hA5}) $display("FAIL single_hold got %b/%h exp 1/a5", rx_if.rx_valid, rx_if.rx_data); else n_pass++;
    rx_if.rx_ready = 1'b1;
    @(negedge clk);
    rx_if.rx_ready = 1'b0;
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL single_drop got %b exp 0", rx_if.rx_valid); else n_pass++;
    n_total++; if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) $display("FAIL single_pulses got %0d exp 0", (fe_cnt - fe0) + (ov_cnt - ov0)); else n_pass++;
  endtask

  task automatic test_glitch();
    int t0, fe0, ov0;
    logic [7:0] d;
    fe0 = fe_cnt; ov0 = ov_cnt;
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (2) @(negedge clk);
    ser_rx = 1'b1;
    repeat (200) @(negedge clk);
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL glitch_valid got %b exp 0", rx_if.rx_valid); else n_pass++;
    n_total++; if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) $display("FAIL glitch_pulses got %0d exp 0", (fe_cnt - fe0) + (ov_cnt - ov0)); else n_pass++;
    send_frame(8'h96, 1'b1, 0, t0);
    pop_byte(d);
    n_total++; if (d !== 8'h96) $display("FAIL glitch_after got %h exp 96", d); else n_pass++;
  endtask

  task automatic test_framing();
    int t0, fe0, ov0;
    logic [7:0] d;
    fe0 = fe_cnt; ov0 = ov_cnt;
    send_frame(8'h3C, 1'b0, 30, t0);
    repeat (20) @(negedge clk);
    n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL framing_count got %0d exp 1", fe_cnt - fe0); else n_pass++;
    n_total++; if (ov_cnt - ov0 !== 0) $display("FAIL framing_overrun got %0d exp 0", ov_cnt - ov0); else n_pass++;
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL framing_empty got %b exp 0", rx_if.rx_valid); else n_pass++;
    send_frame(8'h5A, 1'b1, 0, t0);
    pop_byte(d);
    n_total++; if (d !== 8'h5A) $display("FAIL framing_next got %h exp 5a", d); else n_pass++;
    n_total++; if (fe_cnt - fe0 !== 1) $display("FAIL framing_next_err got %0d exp 1", fe_cnt - fe0); else n_pass++;
  endtask

  task automatic test_overrun();
    int t0, ov0;
    logic [7:0] d, exp_d;
    ov0 = ov_cnt;
    for (int i = 1; i <= 4; i++) send_frame(8'(i), 1'b1, 0, t0);
    n_total++; if (ov_cnt - ov0 !== 0) $display("FAIL overrun_early got %0d exp 0", ov_cnt - ov0); else n_pass++;
    send_frame(8'h05, 1'b1, 0, t0);
    n_total++; if (ov_cnt - ov0 !== 1) $display("FAIL overrun_count got %0d exp 1", ov_cnt - ov0); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      exp_d = 8'(i);
      pop_byte(d);
      n_total++; if (d !== exp_d) $display("FAIL overrun_pop%0d got %h exp %h", i, d, exp_d); else n_pass++;
    end
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL overrun_empty got %b exp 0", rx_if.rx_valid); else n_pass++;
  endtask

  task automatic test_full_pop();
    int t0, ov0, dummy;
    logic [7:0] d, exp_d;
    for (int i = 0; i < 4; i++) send_frame(8'h10 + 8'(i), 1'b1, 0, t0);
    ov0 = ov_cnt;
    fork
      send_frame(8'h14, 1'b1, 0, dummy);
      begin
        repeat (79) @(negedge clk);
        rx_if.rx_ready = 1'b1;
        @(negedge clk);
        rx_if.rx_ready = 1'b0;
      end
    join
    repeat (2) @(negedge clk);
    n_total++; if (ov_cnt - ov0 !== 0) $display("FAIL fullpop_overrun got %0d exp 0", ov_cnt - ov0); else n_pass++;
    for (int i = 1; i <= 4; i++) begin
      exp_d = 8'h10 + 8'(i);
      pop_byte(d);
      n_total++; if (d !== exp_d) $display("FAIL fullpop_pop%0d got %h exp %h", i, d, exp_d); else n_pass++;
    end
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL fullpop_empty got %b exp 0", rx_if.rx_valid); else n_pass++;
  endtask

  task automatic test_reset_midframe();
    int t0, fe0, ov0;
    logic [7:0] d;
    logic [7:0] d77;
    d77 = 8'h77;
    send_frame(8'hC3, 1'b1, 0, t0);
    n_total++; if (rx_if.rx_data !== 8'hC3) $display("FAIL rstmid_pre got %h exp c3", rx_if.rx_data); else n_pass++;
    @(negedge clk);
    ser_rx = 1'b0;
    repeat (8) @(negedge clk);
    for (int i = 0; i < 4; i++) begin
      ser_rx = d77[i];
      repeat (8) @(negedge clk);
    end
    ser_rx = d77[4];
    repeat (4) @(negedge clk);
    resetn = 1'b0;
    #1;
    n_total++; if ({rx_if.rx_valid, rx_if.rx_data, rx_if.frame_err, rx_if.overrun} !== 11'h0)
      $display("FAIL rstmid_async got %b/%h/%b/%b exp 0/00/0/0", rx_if.rx_valid, rx_if.rx_data, rx_if.frame_err, rx_if.overrun); else n_pass++;
    repeat (3) @(negedge clk);
    ser_rx = 1'b1;
    resetn = 1'b1;
    fe0 = fe_cnt; ov0 = ov_cnt;
    repeat (120) @(negedge clk);
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL rstmid_idle got %b exp 0", rx_if.rx_valid); else n_pass++;
    send_frame(8'h00, 1'b1, 0, t0);
    send_frame(8'hFF, 1'b1, 0, t0);
    pop_byte(d);
    n_total++; if (d !== 8'h00) $display("FAIL rstmid_b0 got %h exp 00", d); else n_pass++;
    pop_byte(d);
    n_total++; if (d !== 8'hFF) $display("FAIL rstmid_b1 got %h exp ff", d); else n_pass++;
    n_total++; if (rx_if.rx_valid !== 1'b0) $display("FAIL rstmid_empty got %b exp 0", rx_if.rx_valid); else n_pass++;
    n_total++; if ((fe_cnt - fe0) + (ov_cnt - ov0) !== 0) $display("FAIL rstmid_pulses got %0d exp 0", (fe_cnt - fe0) + (ov_cnt - ov0)); else n_pass++;
  endtask

  initial begin
    rx_if.rx_ready = 1'b0;
    test_reset();
    test_single();
    test_glitch();
    test_framing();
    test_overrun();
    test_full_pop();
    test_reset_midframe();
    n_total++; if (both_cnt !== 0) $display("FAIL pulses_together got %0d exp 0", both_cnt); else n_pass++;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog got timeout exp finish");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
